// File: rtl/aes_pkg.sv
// Shared AES constants, S-box tables and the SubBytes engine state type.
// Pure package: no logic and no latency.
// Backpressure: not applicable.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } subbytes_state_t;

    // Packed [0:255] so element 0 is the leftmost byte of the first row.
    localparam logic [0:255][AES_BYTE_W-1:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][AES_BYTE_W-1:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [AES_BYTE_W-1:0] sbox_f(input logic [AES_BYTE_W-1:0] b,
                                                      input logic inv);
        return inv ? SBOX_INV[b] : SBOX_FWD[b];
    endfunction

endpackage

// File: rtl/subbytes_seq_if.sv
// Input/output handshake bundle of the sequential SubBytes engine.
// Wires only: no latency.
// Backpressure: valid/ready on both the input and the output side.
interface subbytes_seq_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_BLOCK_W-1:0] in_data;
    logic                   in_inv;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_BLOCK_W-1:0] out_data;
    logic                   busy;

    // master: the round controller / downstream pair driving the engine
    modport master (output in_valid, in_data, in_inv, out_ready,
                    input  in_ready, out_valid, out_data, busy);
    // slave: the engine itself
    modport slave  (input  in_valid, in_data, in_inv, out_ready,
                    output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/sbox_lut.sv
// One AES S-box lookup, forward or inverse selected by inv.
// Latency: purely combinational.
// Backpressure: none; ports are in[7:0], inv -> out[7:0].
module sbox_lut
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] in,
    input  logic                  inv,
    output logic [AES_BYTE_W-1:0] out
);
    assign out = sbox_f(in, inv);
endmodule

// File: rtl/subbytes_seq.sv
// Time-multiplexed AES SubBytes: SBOX_LANES bytes per cycle over N = 16/SBOX_LANES cycles.
// Latency: out_valid rises N cycles after the accept edge; one state per N+2 cycles.
// Backpressure: holds DONE with stable out_data until out_ready; in_ready low while busy.
// Ports: clk, rst_n (async, active-low), bus (in_valid/in_ready/in_data/in_inv,
//        out_valid/out_ready/out_data, busy).
module subbytes_seq
    import aes_pkg::*;
#(
    parameter int SBOX_LANES = 4,
    parameter bit INV_EN     = 1'b1
)(
    input  logic          clk,
    input  logic          rst_n,
    subbytes_seq_if.slave bus
);
    localparam int N     = 16 / SBOX_LANES;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam int CHK_W = AES_BYTE_W * SBOX_LANES;

    if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4 &&
        SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
        $error("subbytes_seq: SBOX_LANES must be 1, 2, 4, 8 or 16");
    end

    subbytes_state_t        state, state_nxt;
    logic [CW-1:0]          cnt;
    logic                   mode;
    logic [AES_BLOCK_W-1:0] work;
    logic [AES_BLOCK_W-1:0] result;
    logic [CHK_W-1:0]       lane_in, lane_out;
    logic [N-1:0]           wr_en;
    logic                   accept, last_chunk;

    // Gating with rst_n keeps in_ready low for the whole reset window,
    // even though the state register already sits in IDLE.
    assign bus.in_ready  = (state == IDLE) && rst_n;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = result;

    assign accept     = bus.in_valid && bus.in_ready;
    assign last_chunk = (cnt == CW'(N - 1));

    // Chunk read mux: the current chunk of the working register feeds the lanes.
    assign lane_in = work[int'(cnt) * CHK_W +: CHK_W];

    for (genvar i = 0; i < SBOX_LANES; i++) begin : g_lane
        sbox_lut u_sbox (
            .in  (lane_in[AES_BYTE_W*i +: AES_BYTE_W]),
            .inv (mode),
            .out (lane_out[AES_BYTE_W*i +: AES_BYTE_W])
        );
    end

    always_comb begin
        wr_en = '0;
        for (int c = 0; c < N; c++) begin
            wr_en[c] = (state == RUN) && (cnt == CW'(c));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = RUN;
            RUN:     if (last_chunk)    state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            mode   <= 1'b0;
            work   <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                work <= bus.in_data;
                // Without the inverse table the mode is forced to forward.
                mode <= INV_EN ? bus.in_inv : 1'b0;
                cnt  <= '0;
            end else if (state == RUN) begin
                cnt <= last_chunk ? '0 : cnt + 1'b1;
                for (int c = 0; c < N; c++) begin
                    if (wr_en[c]) result[c*CHK_W +: CHK_W] <= lane_out;
                end
            end
        end
    end
endmodule

// File: tb/tb_subbytes_seq.sv
// Bench for subbytes_seq: six instances (L = 1,2,4,8,16 and L = 16 forward-only),
// each checked against a GF(2^8) inverse + affine model of the S-box.
// Backpressure, mid-run reset, latency and throughput are exercised per instance.
module tb_subbytes_seq;
    localparam int NI = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] in_valid, in_inv, out_ready;
    logic [127:0]  in_data [NI];
    wire  [NI-1:0] in_ready, out_valid, busy;
    wire  [127:0]  out_data [NI];

    int vectors = 0;
    int miscompares = 0;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int LN = (k == 5) ? 16 : (1 << k);
        subbytes_seq_if ifc ();
        assign ifc.in_valid  = in_valid[k];
        assign ifc.in_data   = in_data[k];
        assign ifc.in_inv    = in_inv[k];
        assign ifc.out_ready = out_ready[k];
        assign in_ready[k]   = ifc.in_ready;
        assign out_valid[k]  = ifc.out_valid;
        assign out_data[k]   = ifc.out_data;
        assign busy[k]       = ifc.busy;
        subbytes_seq #(.SBOX_LANES(LN), .INV_EN(k != 5)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc)
        );
    end

    // ---------------- reference model ----------------
    logic [7:0] fwd_m [256];
    logic [7:0] inv_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_model();
        logic [7:0] x, y, iv, s;
        for (int xi = 0; xi < 256; xi++) begin
            x = 8'(xi);
            iv = 8'h00;
            for (int yi = 1; yi < 256; yi++) begin
                y = 8'(yi);
                if (gmul(x, y) == 8'h01) iv = y;
            end
            s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
            fwd_m[xi] = s;
            inv_m[s]  = x;
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input bit inv);
        logic [127:0] r;
        for (int j = 0; j < 16; j++)
            r[8*j +: 8] = inv ? inv_m[d[8*j +: 8]] : fwd_m[d[8*j +: 8]];
        return r;
    endfunction

    function automatic int lanes_of(input int k);
        return (k == 5) ? 16 : (1 << k);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one transaction on instance k; returns result and cycles from accept to out_valid.
    task automatic run_txn(input int k, input logic [127:0] d, input bit inv,
                           output logic [127:0] res, output int lat, output bit ok);
        int n;
        ok = 1'b1; lat = 0; res = '0;
        @(negedge clk);
        n = 0;
        while (!in_ready[k] && n < 50) begin @(negedge clk); n++; end
        if (!in_ready[k]) begin ok = 1'b0; return; end
        in_data[k] = d; in_inv[k] = inv; in_valid[k] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        in_inv[k]   = ~inv;      // must not affect the transaction in flight
        in_data[k]  = ~d;
        while (!out_valid[k] && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!out_valid[k]) ok = 1'b0;
        res = out_data[k];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            vectors += 4;
            if (in_ready[k] !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready[%0d]: got %b want 0", k, in_ready[k]); end
            if (out_valid[k] !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, out_valid[k]); end
            if (busy[k] !== 1'b0) begin miscompares++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
            if (out_data[k] !== 128'h0) begin miscompares++; $display("FAIL reset_out_data[%0d]: got %h want 0", k, out_data[k]); end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if (in_ready[k] !== 1'b1) begin miscompares++; $display("FAIL release_in_ready[%0d]: got %b want 1", k, in_ready[k]); end
        end
    endtask

    task automatic test_zero_all_lanes();
        logic [127:0] res; int lat; bit ok;
        for (int k = 0; k < NI; k++) begin
            out_ready[k] = 1'b1;
            run_txn(k, 128'h0, 1'b0, res, lat, ok);
            vectors += 3;
            if (!ok) begin miscompares++; $display("FAIL zero_timeout[%0d]: got timeout want completion", k); end
            if (res !== {16{8'h63}}) begin miscompares++; $display("FAIL zero_data[%0d]: got %h want %h", k, res, {16{8'h63}}); end
            if (lat != 16 / lanes_of(k)) begin miscompares++; $display("FAIL zero_latency[%0d]: got %0d want %0d", k, lat, 16 / lanes_of(k)); end
            @(posedge clk); #1;
            vectors++;
            if (out_valid[k] !== 1'b0) begin miscompares++; $display("FAIL zero_handshake[%0d]: got out_valid %b want 0", k, out_valid[k]); end
        end
    endtask

    task automatic test_fips_and_inverse();
        logic [127:0] res, res2, d; int lat; bit ok;
        run_txn(2, 128'h0848f8e92a8dc69a2be2f4a0bee33d19, 1'b0, res, lat, ok);
        vectors += 2;
        if (!ok) begin miscompares++; $display("FAIL fips_timeout: got timeout want completion"); end
        if (res !== 128'h3052411ee55db4b8f198bfe0ae1127d4) begin miscompares++; $display("FAIL fips_fwd: got %h want %h", res, 128'h3052411ee55db4b8f198bfe0ae1127d4); end
        run_txn(0, res, 1'b1, res2, lat, ok);
        vectors += 2;
        if (!ok) begin miscompares++; $display("FAIL roundtrip_timeout: got timeout want completion"); end
        if (res2 !== 128'h0848f8e92a8dc69a2be2f4a0bee33d19) begin miscompares++; $display("FAIL roundtrip_inv: got %h want %h", res2, 128'h0848f8e92a8dc69a2be2f4a0bee33d19); end
        d = rand128();
        d[7:0] = 8'h63; d[15:8] = 8'hed;
        run_txn(2, d, 1'b1, res, lat, ok);
        vectors += 3;
        if (res[7:0] !== 8'h00) begin miscompares++; $display("FAIL inv_63: got %h want 00", res[7:0]); end
        if (res[15:8] !== 8'h53) begin miscompares++; $display("FAIL inv_ed: got %h want 53", res[15:8]); end
        if (res !== model(d, 1'b1)) begin miscompares++; $display("FAIL inv_state: got %h want %h", res, model(d, 1'b1)); end
        // forward-only instance ignores in_inv
        d = rand128();
        run_txn(5, d, 1'b1, res, lat, ok);
        vectors++;
        if (res !== model(d, 1'b0)) begin miscompares++; $display("FAIL fwd_only: got %h want %h", res, model(d, 1'b0)); end
    endtask

    task automatic test_backpressure();
        logic [127:0] res, d; int lat; bit ok;
        d = rand128();
        out_ready[2] = 1'b0;
        run_txn(2, d, 1'b0, res, lat, ok);
        vectors += 2;
        if (!ok) begin miscompares++; $display("FAIL bp_timeout: got timeout want completion"); end
        if (res !== model(d, 1'b0)) begin miscompares++; $display("FAIL bp_data: got %h want %h", res, model(d, 1'b0)); end
        for (int c = 0; c < 10; c++) begin
            in_valid[2] = c[0];
            in_data[2]  = rand128();
            @(posedge clk); #1;
            vectors += 3;
            if (out_valid[2] !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want 1", c, out_valid[2]); end
            if (out_data[2] !== res) begin miscompares++; $display("FAIL bp_hold[%0d]: got %h want %h", c, out_data[2], res); end
            if (in_ready[2] !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready[2]); end
        end
        in_valid[2] = 1'b0;
        out_ready[2] = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid[2] !== 1'b0) begin miscompares++; $display("FAIL bp_release: got out_valid %b want 0", out_valid[2]); end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy[2] !== 1'b0) begin miscompares++; $display("FAIL bp_not_queued: got busy %b want 0", busy[2]); end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] res, d; int lat; bit ok; int n;
        out_ready[1] = 1'b1;
        @(negedge clk);
        n = 0;
        while (!in_ready[1] && n < 50) begin @(negedge clk); n++; end
        in_data[1] = rand128(); in_inv[1] = 1'b0; in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        repeat (3) @(posedge clk);   // chunk counter now at 3 of 8
        #2;
        vectors++;
        if (busy[1] !== 1'b1) begin miscompares++; $display("FAIL midrun_busy_before: got %b want 1", busy[1]); end
        rst_n = 1'b0;
        #1;
        vectors += 4;
        if (out_valid[1] !== 1'b0) begin miscompares++; $display("FAIL midrun_out_valid: got %b want 0", out_valid[1]); end
        if (out_data[1] !== 128'h0) begin miscompares++; $display("FAIL midrun_out_data: got %h want 0", out_data[1]); end
        if (busy[1] !== 1'b0) begin miscompares++; $display("FAIL midrun_busy: got %b want 0", busy[1]); end
        if (in_ready[1] !== 1'b0) begin miscompares++; $display("FAIL midrun_in_ready: got %b want 0", in_ready[1]); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        vectors += 2;
        if (in_ready[1] !== 1'b1) begin miscompares++; $display("FAIL midrun_release_ready: got %b want 1", in_ready[1]); end
        if (out_valid[1] !== 1'b0) begin miscompares++; $display("FAIL midrun_no_output: got %b want 0", out_valid[1]); end
        d = rand128();
        run_txn(1, d, 1'b1, res, lat, ok);
        vectors += 2;
        if (!ok || lat != 8) begin miscompares++; $display("FAIL midrun_retry_latency: got %0d want 8", lat); end
        if (res !== model(d, 1'b1)) begin miscompares++; $display("FAIL midrun_retry_data: got %h want %h", res, model(d, 1'b1)); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] res, d; int lat; bit ok; int k; bit inv;
        int acc_t [$];
        out_ready = '1;
        for (int t = 0; t < 24; t++) begin
            k = int'($urandom_range(5, 0));
            inv = 1'($urandom);
            d = rand128();
            run_txn(k, d, inv, res, lat, ok);
            vectors++;
            if (!ok || res !== model(d, inv && (k != 5))) begin
                miscompares++;
                $display("FAIL b2b[%0d] k=%0d inv=%0d: got %h want %h", t, k, inv, res, model(d, inv && (k != 5)));
            end
        end
        run_txn(4, {16{8'hff}}, 1'b0, res, lat, ok);
        vectors++;
        if (res !== {16{8'h16}}) begin miscompares++; $display("FAIL ff_fwd: got %h want %h", res, {16{8'h16}}); end
        // throughput on L=8: in_valid held high, accepts should be N+2 = 4 cycles apart
        @(negedge clk);
        in_valid[3] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (in_ready[3]) begin acc_t.push_back(c); in_data[3] = rand128(); end
            @(negedge clk);
        end
        in_valid[3] = 1'b0;
        vectors++;
        if (acc_t.size() < 4) begin miscompares++; $display("FAIL tput_count: got %0d want >=4", acc_t.size()); end
        for (int i = 1; i < acc_t.size(); i++) begin
            vectors++;
            if (acc_t[i] - acc_t[i-1] != 4) begin miscompares++; $display("FAIL tput_gap[%0d]: got %0d want 4", i, acc_t[i] - acc_t[i-1]); end
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = '0; in_inv = '0; out_ready = '0;
        for (int k = 0; k < NI; k++) in_data[k] = '0;
        build_model();
        test_reset();
        test_zero_all_lanes();
        test_fips_and_inverse();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/subbytes_seq.md
# subbytes_seq

Parametrised, time-multiplexed AES SubBytes engine with forward and inverse substitution. It is the successor to the fixed 16-lane SubBytes stage. It processes one 128-bit state per transaction using SBOX_LANES S-box instances over 16/SBOX_LANES cycles, so area can be traded against latency. Valid/ready handshakes on both sides let it sit between the round controller and ShiftRows in either the encrypt or the decrypt datapath.

## Interface
- SBOX_LANES, 4, number of parallel S-box lookups per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- INV_EN, 1, 1 instantiates the inverse table. 0 means forward only, and in_inv is ignored.
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- in_valid, input, 1, the input state is offered.
- in_ready, output, 1, the block can accept a state.
- in_data, input, 128, input state. Byte j is in_data[8*j +: 8].
- in_inv, input, 1, mode for this transaction. 0 selects forward S-box, 1 selects inverse S-box. Sampled with in_data.
- out_valid, output, 1, out_data holds a completed result.
- out_ready, input, 1, downstream accepts the result.
- out_data, output, 128, substituted state, with the same byte ordering as in_data.
- busy, output, 1, high in RUN and DONE.

## Operation
- N = 16 / SBOX_LANES chunks. The chunk counter cnt is clog2(N) bits wide, or 1 bit when N = 1.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch in_data into the working register and latch in_inv into the mode flop.
  - Set cnt = 0 and go to RUN.
- RUN:
  - Each cycle, substitute bytes cnt*L .. cnt*L+L-1 (L = SBOX_LANES) through the table selected by the mode flop.
  - Write the results into the same byte positions of the result register.
  - Increment cnt.
  - When cnt == N-1, go to DONE on that edge.
- DONE:
  - out_valid = 1.
  - out_data and out_valid stay stable until out_ready is high.
  - On out_valid && out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE. A new input is never accepted in the same cycle as an output handshake.
- The mode flop is held for the whole transaction. Changing in_inv mid-transaction has no effect.
- S-box lookups are purely combinational within the cycle. They are not pipelined.
- When INV_EN = 0, the forward table is always used.

## Timing
- Reset values, with rst_n low, asynchronous:
  - state = IDLE, cnt = 0, mode = 0.
  - Working and result registers = 0.
  - out_valid = 0, out_data = 0, busy = 0.
  - in_ready = 0 while rst_n is low. It becomes 1 in the first cycle after release.
- Latency: the accept edge is t0. out_valid rises after edge tN, i.e. N cycles after acceptance.
  - L = 16: 1 cycle.
  - L = 4: 4 cycles.
  - L = 1: 16 cycles.
- Throughput: with out_ready tied high, one state every N+2 cycles. The phases are accept, N RUN cycles, and the DONE handshake.
- Backpressure: DONE persists for any number of cycles with out_data unchanged.
- Reset asserted mid-RUN or mid-DONE:
  - Return to IDLE immediately and drop out_valid.
  - The partial result is discarded. No output is produced for the aborted transaction.
- in_valid asserted during RUN or DONE is ignored, not queued. The source must hold it until in_ready.

## Structure
- Shared package aes_pkg holds:
  - the AES_BLOCK_W = 128 and AES_BYTE_W = 8 constants;
  - the 256-entry forward and inverse S-box constant arrays;
  - the subbytes_state_t enum (IDLE, RUN, DONE).
- The package also provides a function sbox_f(byte, inv) used by the sub-module.
- One sub-module, sbox_lut: combinational, with inputs in[7:0] and inv and output out[7:0]. It is instantiated SBOX_LANES times in a generate loop.
- Lane i reads byte cnt*L+i through a mux over N chunks. Its result is written back through per-chunk write enables.

## Test plan
- All-zero input, forward, every legal SBOX_LANES -> out_data = 0x63 in every byte; out_valid after exactly N cycles.
- FIPS-197 round-1 vector, forward, bytes listed byte 0 first:
  - Stimulus: 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08.
  - Required response: d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
- Inverse round-trip: feed that output with in_inv = 1 -> the original input is returned. Byte spot checks: inverse of 0x63 = 0x00, inverse of 0xED = 0x53.
- Backpressure: hold out_ready low for 10 cycles in DONE -> out_data and out_valid stay constant; in_ready stays 0; in_valid pulses are not accepted.
- Reset mid-RUN with L = 2, asserting rst_n low at cnt = 3 -> out_valid = 0 and out_data = 0 immediately. After release, in_ready = 1, and a new transaction completes correctly.
- Back-to-back random states with random in_inv and out_ready tied high -> results match the reference model; 0xFF forward gives 0x16.
